// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key 2-flop synchronizer, debounce FSM, press/release pulses.
// Optional long-press detection is built when KEY_COND_LONG_PRESS_EN is defined.
module key_conditioner #(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 1000,
    parameter int N_KEYS        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    // 64-bit products so the default clock and hold times cannot overflow
    localparam longint DB_RAW    = (longint'(CLOCK_FREQ) * longint'(DEBOUNCE_MS)) / 1000;
    localparam int     DB_CYCLES = (DB_RAW == 0) ? 1 : int'(DB_RAW);
    localparam int     DW        = $clog2(DB_CYCLES + 1);

`ifdef KEY_COND_LONG_PRESS_EN
    localparam longint LP_RAW    = (longint'(CLOCK_FREQ) * longint'(LONG_PRESS_MS)) / 1000;
    localparam int     LP_CYCLES = (LP_RAW == 0) ? 1 : int'(LP_RAW);
    localparam int     HW        = $clog2(LP_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic          s1, s2, raw, done;
        logic [DW-1:0] cnt;
        state_t        state;
        logic          pressed_q, press_q, release_q;

        assign raw  = ~s2;
        // next increment would reach DB_CYCLES
        assign done = (cnt == DW'(DB_CYCLES - 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1        <= 1'b1;
                s2        <= 1'b1;
                cnt       <= '0;
                state     <= RELEASED;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                s1        <= key_n[i];
                s2        <= s1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state)
                    RELEASED, PRESS_WAIT: begin
                        if (!raw) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (done) begin
                            state     <= HELD;
                            cnt       <= '0;
                            pressed_q <= 1'b1;
                            press_q   <= 1'b1;
                        end else begin
                            state <= PRESS_WAIT;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    HELD, RELEASE_WAIT: begin
                        if (raw) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (done) begin
                            state     <= RELEASED;
                            cnt       <= '0;
                            pressed_q <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            state <= RELEASE_WAIT;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign pressed[i]       = pressed_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;

`ifdef KEY_COND_LONG_PRESS_EN
        logic [HW-1:0] hold_cnt;
        logic          long_q;

        // hold_cnt equals cycles since the press edge, saturating at LP_CYCLES
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                long_q <= pressed_q && (hold_cnt == HW'(LP_CYCLES - 1));
                if (!pressed_q)
                    hold_cnt <= '0;
                else if (hold_cnt != HW'(LP_CYCLES))
                    hold_cnt <= hold_cnt + 1'b1;
            end
        end

        assign long_pulse[i] = long_q;
`else
        assign long_pulse[i] = 1'b0;
`endif
    end

endmodule
